// File: rtl/tile_accum_mem_pkg.sv
// Shared arithmetic for the K-tile accumulator: sign extension and
// saturating/wrapping add on a wide signed carrier, narrowed by the caller.
package tile_accum_mem_pkg;
  localparam int MAXW = 64;
  typedef logic signed [MAXW-1:0] wide_t;

  // x carries a w-bit value in its low bits; replicate bit w-1 upward
  function automatic wide_t sign_ext(input wide_t x, input int w);
    wide_t t;
    t = x <<< (MAXW - w);
    return t >>> (MAXW - w);
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w,
                                    input logic sat, output logic ovf);
    wide_t s, hi, lo, r;
    s   = a + b;
    hi  = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo  = -hi - wide_t'(1);
    ovf = (s > hi) || (s < lo);
    if (sat && s > hi)      r = hi;
    else if (sat && s < lo) r = lo;
    else                    r = sign_ext(s, w);
    return r;
  endfunction
endpackage

// File: rtl/tile_accum_mem_if.sv
// Row-stream bus between the MXU side (master) and the accumulator (slave).
interface tile_accum_mem_if #(
  parameter int LANES     = 8,
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 40,
  parameter int DEPTH     = 64
);
  logic [$clog2(DEPTH):0]          tile_m;
  logic [LANES-1:0][ACC_WIDTH-1:0] bias;
  logic [LANES-1:0][IN_WIDTH-1:0]  d;
  logic                            d_valid, d_first_k, d_last_k;
  logic [LANES-1:0][ACC_WIDTH-1:0] q;
  logic                            q_valid, q_last_row;
  logic                            ovf, clr_ovf, idle;

  modport master (output tile_m, bias, d, d_valid, d_first_k, d_last_k, clr_ovf,
                  input  q, q_valid, q_last_row, ovf, idle);
  modport slave  (input  tile_m, bias, d, d_valid, d_first_k, d_last_k, clr_ovf,
                  output q, q_valid, q_last_row, ovf, idle);
endinterface

// File: rtl/tile_accum_ram.sv
// Partial-sum row store: synchronous read, one write port, and a same-address
// bypass so a read issued during the write of that row sees the new data.
module tile_accum_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 320
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/tile_accum_mem.sv
// K-tile partial-sum accumulator: row counter + RAM read in stage 0,
// add/saturate + write-back or output register in stage 1 (latency 2).
module tile_accum_mem
  import tile_accum_mem_pkg::*;
#(
  parameter int LANES     = 8,
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 40,
  parameter int DEPTH     = 64,
  parameter int SATURATE  = 0,
  parameter int USE_BIAS  = 0
) (
  input logic             clk,
  input logic             resetn,
  tile_accum_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef acc_t [LANES-1:0]            acc_row_t;
  typedef struct packed {
    logic                           first;
    logic                           last;
    logic                           last_row;
    logic [AW-1:0]                  row;
    logic [LANES-1:0][IN_WIDTH-1:0] d;
  } s1_t;

  // vld_pipe[0]: beat in the add stage; vld_pipe[1]: output register loaded
  logic [1:0]       vld_pipe;
  s1_t              s1;
  logic [AW-1:0]    row, row_end;
  logic [AW:0]      tile_m_r, tm;
  acc_row_t         rd_row, sum_row, q_r;
  logic [LANES-1:0] lane_ovf;
  logic             emit_r, last_row_r, ovf_r, idle, q_valid;

  assign idle    = (row == '0) && !vld_pipe[0];
  // while idle the live tile_m governs, so a beat on the first idle cycle wraps correctly
  assign tm      = idle ? bus.tile_m : tile_m_r;
  assign row_end = AW'(tm - (AW+1)'(1));

  tile_accum_ram #(.DEPTH(DEPTH), .W(LANES*ACC_WIDTH)) u_ram (
    .clk   (clk),
    .we    (vld_pipe[0] & ~s1.last),
    .waddr (s1.row),
    .wdata (sum_row),
    .re    (bus.d_valid & ~bus.d_first_k),
    .raddr (row),
    .rdata (rd_row)
  );

  always_comb begin
    wide_t base, inc;
    logic  o;
    base     = '0;
    inc      = '0;
    o        = 1'b0;
    sum_row  = '0;
    lane_ovf = '0;
    for (int l = 0; l < LANES; l++) begin
      if (s1.first) base = (USE_BIAS != 0) ? sign_ext(wide_t'(bus.bias[l]), ACC_WIDTH) : '0;
      else          base = sign_ext(wide_t'(rd_row[l]), ACC_WIDTH);
      inc         = sign_ext(wide_t'(s1.d[l]), IN_WIDTH);
      sum_row[l]  = acc_t'(sat_add(base, inc, ACC_WIDTH, SATURATE != 0, o));
      lane_ovf[l] = o;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe   <= '0;
      s1         <= '0;
      row        <= '0;
      tile_m_r   <= '0;
      q_r        <= '0;
      emit_r     <= 1'b0;
      last_row_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], bus.d_valid};
      if (idle) tile_m_r <= bus.tile_m;
      if (bus.d_valid) begin
        row         <= (row == row_end) ? '0 : row + AW'(1);
        s1.first    <= bus.d_first_k;
        s1.last     <= bus.d_last_k;
        s1.last_row <= (row == row_end);
        s1.row      <= row;
        s1.d        <= bus.d;
      end
      if (vld_pipe[0]) begin
        emit_r     <= s1.last;
        last_row_r <= s1.last_row;
        if (s1.last) q_r <= sum_row;
      end
      // a fresh overflow wins over a simultaneous clear
      ovf_r <= (vld_pipe[0] & |lane_ovf) | (ovf_r & ~bus.clr_ovf);
    end
  end

  assign q_valid        = vld_pipe[1] & emit_r;
  assign bus.q          = q_r;
  assign bus.q_valid    = q_valid;
  assign bus.q_last_row = q_valid & last_row_r;
  assign bus.ovf        = ovf_r;
  assign bus.idle       = idle;
endmodule

// File: tb/tb_tile_accum_mem.sv
// Bench: default-geometry instance against a row/lane sum model, plus two
// 8-bit instances (saturating+bias, wrapping) for the boundary cases.
module tb_tile_accum_mem;
  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tile_accum_mem_if #(.LANES(8), .IN_WIDTH(32), .ACC_WIDTH(40), .DEPTH(64)) ifa ();
  tile_accum_mem_if #(.LANES(2), .IN_WIDTH(8),  .ACC_WIDTH(8),  .DEPTH(4))  ifs ();
  tile_accum_mem_if #(.LANES(2), .IN_WIDTH(8),  .ACC_WIDTH(8),  .DEPTH(4))  ifw ();

  tile_accum_mem #(.LANES(8), .IN_WIDTH(32), .ACC_WIDTH(40), .DEPTH(64), .SATURATE(0), .USE_BIAS(0))
    dut_a (.clk(clk), .resetn(resetn), .bus(ifa));
  tile_accum_mem #(.LANES(2), .IN_WIDTH(8), .ACC_WIDTH(8), .DEPTH(4), .SATURATE(1), .USE_BIAS(1))
    dut_s (.clk(clk), .resetn(resetn), .bus(ifs));
  tile_accum_mem #(.LANES(2), .IN_WIDTH(8), .ACC_WIDTH(8), .DEPTH(4), .SATURATE(0), .USE_BIAS(0))
    dut_w (.clk(clk), .resetn(resetn), .bus(ifw));

  // wrapping instance sees exactly the saturating instance's stimulus
  assign ifw.tile_m    = ifs.tile_m;
  assign ifw.bias      = ifs.bias;
  assign ifw.d         = ifs.d;
  assign ifw.d_valid   = ifs.d_valid;
  assign ifw.d_first_k = ifs.d_first_k;
  assign ifw.d_last_k  = ifs.d_last_k;
  assign ifw.clr_ovf   = ifs.clr_ovf;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // reference model for dut_a: per-row partial sums, expected output queue
  typedef struct packed { int cyc; logic lr; logic [7:0][39:0] v; } exp_t;
  exp_t   expq[$];
  exp_t   me;
  longint macc [64][8];
  longint din  [8];
  int     rowm = 0, tma = 4;
  bit     movf = 1'b0;

  function automatic longint w40(longint x);
    return (x <<< 24) >>> 24;
  endfunction

  task automatic set_din(input longint val);
    for (int i = 0; i < 8; i++) din[i] = val;
  endtask

  task automatic step_a(input bit v, input bit f, input bit l);
    exp_t   e;
    longint s;
    @(posedge clk); #1;
    ifa.d_valid = v; ifa.d_first_k = f; ifa.d_last_k = l;
    for (int i = 0; i < 8; i++) ifa.d[i] = din[i][31:0];
    if (v) begin
      e     = '0;
      e.cyc = cyc + 2;
      e.lr  = (rowm == tma - 1);
      for (int i = 0; i < 8; i++) begin
        s = (f ? 64'sd0 : macc[rowm][i]) + din[i];
        if (w40(s) != s) movf = 1'b1;
        if (l) e.v[i] = s[39:0];
        else   macc[rowm][i] = w40(s);
      end
      if (l) expq.push_back(e);
      rowm = (rowm == tma - 1) ? 0 : rowm + 1;
    end
  endtask

  task automatic sbeat(input bit v, input bit f, input bit l, input logic [7:0] d0, input logic [7:0] d1);
    @(posedge clk); #1;
    ifs.d_valid = v; ifs.d_first_k = f; ifs.d_last_k = l;
    ifs.d[0] = d0; ifs.d[1] = d1;
  endtask

  // after the last beat: no output one edge later, output on the second edge
  task automatic s_wait_out();
    sbeat(0, 0, 0, 8'd0, 8'd0);
    @(negedge clk);
    chk("s_lat1_qvalid", ifs.q_valid, 0);
    chk("w_lat1_qvalid", ifw.q_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("s_qvalid", ifs.q_valid, 1);
    chk("w_qvalid", ifw.q_valid, 1);
  endtask

  always @(negedge clk) if (resetn) begin
    if (ifa.q_valid) begin
      if (expq.size() == 0) chk("a_extra_qvalid", 1, 0);
      else begin
        me = expq.pop_front();
        chk("a_latency", cyc, me.cyc);
        chk("a_q_last_row", ifa.q_last_row, me.lr);
        for (int i = 0; i < 8; i++) chk("a_q", $signed(ifa.q[i]), $signed(me.v[i]));
      end
    end else chk("a_last_row_noval", ifa.q_last_row, 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (checks %0d)", checks);
    $fatal(1, "timeout");
  end

  initial begin
    ifa.tile_m = 7'd4; ifa.bias = '0; ifa.d = '0; ifa.d_valid = 0;
    ifa.d_first_k = 0; ifa.d_last_k = 0; ifa.clr_ovf = 0;
    ifs.tile_m = 3'd1; ifs.bias = '0; ifs.d = '0; ifs.d_valid = 0;
    ifs.d_first_k = 0; ifs.d_last_k = 0; ifs.clr_ovf = 0;
    set_din(0);
    #12;
    chk("rst_q_valid", ifa.q_valid, 0);
    chk("rst_q", |ifa.q, 0);
    chk("rst_q_last_row", ifa.q_last_row, 0);
    chk("rst_ovf", ifa.ovf, 0);
    chk("rst_idle", ifa.idle, 1);
    @(posedge clk); #1 resetn = 1'b1;

    // saturate / wrap: lane0 100+100, lane1 1+1
    sbeat(1, 1, 0, 8'd100, 8'd1);
    sbeat(1, 0, 1, 8'd100, 8'd1);
    s_wait_out();
    chk("s_q0_sat", $signed(ifs.q[0]), 127);
    chk("s_q1", $signed(ifs.q[1]), 2);
    chk("s_ovf", ifs.ovf, 1);
    chk("s_last_row", ifs.q_last_row, 1);
    chk("w_q0_wrap", $signed(ifw.q[0]), -56);
    chk("w_ovf", ifw.ovf, 1);
    @(posedge clk); #1 ifs.clr_ovf = 1'b1;
    @(posedge clk); #1 ifs.clr_ovf = 1'b0;
    @(negedge clk);
    chk("s_ovf_clr", ifs.ovf, 0);
    chk("w_ovf_clr", ifw.ovf, 0);

    // bias -10: K=1 then K=2, d=3
    ifs.bias[0] = 8'hF6; ifs.bias[1] = 8'hF6;
    sbeat(1, 1, 1, 8'd3, 8'd3);
    s_wait_out();
    chk("s_bias_k1", $signed(ifs.q[0]), -7);
    chk("w_nobias_k1", $signed(ifw.q[1]), 3);
    sbeat(1, 1, 0, 8'd3, 8'd3);
    sbeat(1, 0, 1, 8'd3, 8'd3);
    s_wait_out();
    chk("s_bias_k2", $signed(ifs.q[1]), -4);
    chk("w_nobias_k2", $signed(ifw.q[0]), 6);
    chk("s_ovf_quiet", ifs.ovf, 0);

    // tile_m=4, K=3, d=1, two tiles back to back
    set_din(1);
    for (int t = 0; t < 2; t++)
      for (int k = 0; k < 3; k++)
        for (int r = 0; r < 4; r++) begin
          step_a(1, k == 0, k == 2);
          if (t == 0 && k == 0 && r == 1) begin
            @(negedge clk);
            chk("a_busy", ifa.idle, 0);
          end
        end
    repeat (4) step_a(0, 0, 0);
    @(negedge clk);
    chk("a_idle_after", ifa.idle, 1);

    // tile_m=1, K=5, d=7 back to back: exercises the bypass
    tma = 1; ifa.tile_m = 7'd1;
    set_din(7);
    for (int k = 0; k < 5; k++) step_a(1, k == 0, k == 4);
    repeat (4) step_a(0, 0, 0);

    // reset while row 2 of a K=1 tile is in flight
    tma = 4; ifa.tile_m = 7'd4;
    set_din(5);
    for (int r = 0; r < 3; r++) step_a(1, 1, 1);
    @(posedge clk); #1;
    resetn = 1'b0; ifa.d_valid = 0;
    expq.delete(); rowm = 0; movf = 1'b0;
    #2;
    chk("mid_rst_q_valid", ifa.q_valid, 0);
    chk("mid_rst_q", |ifa.q, 0);
    chk("mid_rst_last_row", ifa.q_last_row, 0);
    chk("mid_rst_ovf", ifa.ovf, 0);
    chk("mid_rst_idle", ifa.idle, 1);
    @(posedge clk); #1 resetn = 1'b1;
    tma = 3; ifa.tile_m = 7'd3;
    set_din(2);
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 3; r++) step_a(1, k == 0, k == 1);
    repeat (4) step_a(0, 0, 0);

    // random data, ~30% idle gaps, tile_m=DEPTH, K=4
    tma = 64; ifa.tile_m = 7'd64;
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 64; r++) begin
        while ($urandom_range(0, 9) < 3) step_a(0, 0, 0);
        for (int i = 0; i < 8; i++) din[i] = longint'($signed($urandom()));
        step_a(1, k == 0, k == 3);
      end
    repeat (5) step_a(0, 0, 0);
    @(negedge clk);
    chk("a_pending_outputs", expq.size(), 0);
    chk("a_ovf_final", ifa.ovf, movf);
    chk("a_idle_final", ifa.idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
